// File: rtl/ks_multiword_adder_seq.sv
// ks_multiword_adder_seq: byte-serial multi-precision adder that reuses one 8-bit Kogge-Stone adder.
// Optional subtract mode (adds the sub port) is enabled by defining KSSEQ_SUB_EN.

module kogge_stone_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [8:0] c;

    assign g0 = a & b;
    assign p0 = a ^ b;

    // Parallel-prefix levels at spans 1, 2 and 4
    always_comb begin
        g1 = g0;
        p1 = p0;
        for (int i = 1; i < 8; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end
    end

    always_comb begin
        g2 = g1;
        p2 = p1;
        for (int i = 2; i < 8; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end
    end

    always_comb begin
        g3 = g2;
        p3 = p2;
        for (int i = 4; i < 8; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
            p3[i] = p2[i] & p2[i-4];
        end
    end

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g3[i] | (p3[i] & cin);
        end
    end

    assign sum  = p0 ^ c[7:0];
    assign cout = c[8];
endmodule

module ks_multiword_adder_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
`ifdef KSSEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [W-1:0]  a_reg, b_reg, b_load;
    logic          carry, carry_load;
    logic [IW-1:0] idx;
    logic          accept, last;
    logic [7:0]    a_byte, b_byte, byte_sum;
    logic          byte_cout;

`ifdef KSSEQ_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign last = (idx == LAST);

    always_comb begin
        a_byte = a_reg[7:0];
        b_byte = b_reg[7:0];
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                a_byte = a_reg[8*i +: 8];
                b_byte = b_reg[8*i +: 8];
            end
        end
    end

    kogge_stone_adder u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b_load;
            carry <= carry_load;
            idx   <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (idx == IW'(i)) begin
                    sum[8*i +: 8] <= byte_sum;
                end
            end
            carry <= byte_cout;
            // idx parks on the last byte instead of wrapping
            if (last) begin
                cout <= byte_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ks_multiword_adder_seq.sv
// Scoreboard bench for ks_multiword_adder_seq with a 4-byte and a 1-byte instance.
`timescale 1ns/1ps
module tb_ks_multiword_adder_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;
`ifdef KSSEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, cin, busy, done, cout;
    logic [W-1:0] a, b, sum;
    logic         start1, cin1, busy1, done1, cout1;
    logic [7:0]   a1, b1, sum1;
`ifdef KSSEQ_SUB_EN
    logic         sub, sub1;
`endif

    logic [W:0] exp_q[$];
    logic [8:0] exp1_q[$];
    int n_vec = 0;
    int n_err = 0;

    ks_multiword_adder_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef KSSEQ_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    ks_multiword_adder_seq #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef KSSEQ_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        logic [W:0] e;
        if (s && SUB_EN) e = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else             e = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        exp_q.push_back(e);
        a = x;
        b = y;
        cin = c;
`ifdef KSSEQ_SUB_EN
        sub = s;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'b1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3*NB + 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset;
        n_vec++;
        if ({busy, done, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL por_outputs: busy=%b done=%b cout=%b sum=%h, required all zero", busy, done, cout, sum);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if (sum !== 32'h0000_6789 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL partial_sum: sum=%h busy=%b, required 00006789 busy=1", sum, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: busy=%b done=%b cout=%b sum=%h, required all zero", busy, done, cout, sum);
        end
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_idle: busy=%b done=%b, required 0 0", busy, done);
            end
        end
    endtask

    task automatic test_basic;
        int cyc;
        logic [W:0] e;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: busy=%b, required 1", busy);
        end
        wait_done(cyc);
        n_vec++;
        if (cyc != NB) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles, required %0d", cyc, NB);
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({cout, sum} !== e) begin
            n_err++;
            $display("FAIL basic_result: got %b_%h, required %b_%h", cout, sum, e[W], e[W-1:0]);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== e) begin
            n_err++;
            $display("FAIL basic_pulse_hold: done=%b busy=%b result=%b_%h, required 0 0 %b_%h",
                     done, busy, cout, sum, e[W], e[W-1:0]);
        end
    endtask

    task automatic test_ripple;
        int cyc;
        logic [W:0] e;
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        wait_done(cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({cout, sum} !== e || cyc != NB) begin
            n_err++;
            $display("FAIL ripple_result: got %b_%h after %0d, required %b_%h after %0d",
                     cout, sum, cyc, e[W], e[W-1:0], NB);
        end
    endtask

    task automatic test_handshake;
        int cyc;
        logic [W:0] e;
        issue(32'h89AB_CDEF, 32'h0123_4567, 1'b1, 1'b0);
        @(posedge clk); #1;
        a = 32'hDEAD_BEEF;
        b = 32'hCAFE_F00D;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({cout, sum} !== e || cyc != NB - 2) begin
            n_err++;
            $display("FAIL ignore_start: got %b_%h at %0d, required %b_%h at %0d",
                     cout, sum, cyc, e[W], e[W-1:0], NB - 2);
        end
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL not_queued: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [W:0] e;
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        for (int k = 0; k < 8; k++) begin
            wait_done(cyc);
            e = exp_q.pop_front();
            n_vec++;
            if ({cout, sum} !== e || cyc != NB) begin
                n_err++;
                $display("FAIL b2b_result[%0d]: got %b_%h at %0d, required %b_%h at %0d",
                         k, cout, sum, cyc, e[W], e[W-1:0], NB);
            end
            if (k < 7) begin
                issue(W'($urandom), (k == 3) ? ~W'(0) : W'($urandom), 1'($urandom), 1'b0);
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_no_idle[%0d]: busy=%b, required 1", k, busy);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub;
        int cyc;
        logic [W:0] e;
        logic [W-1:0] xs [4] = '{32'h0000_0005, 32'h0000_0007, 32'h8000_0000, 32'h1234_5678};
        logic [W-1:0] ys [4] = '{32'h0000_0007, 32'h0000_0005, 32'h8000_0000, 32'h0000_0001};
        logic         ss [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            issue(xs[k], ys[k], 1'b0, ss[k]);
            wait_done(cyc);
            e = exp_q.pop_front();
            n_vec++;
            if ({cout, sum} !== e) begin
                n_err++;
                $display("FAIL sub_result[%0d]: got %b_%h, required %b_%h", k, cout, sum, e[W], e[W-1:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nbytes1;
        logic [8:0] e;
        logic [7:0] xs [2] = '{8'hF0, 8'hFF};
        logic [7:0] ys [2] = '{8'h20, 8'h01};
        logic       cs [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            exp1_q.push_back({1'b0, xs[k]} + {1'b0, ys[k]} + {8'h00, cs[k]});
            a1 = xs[k];
            b1 = ys[k];
            cin1 = cs[k];
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            a1 = 8'h00;
            b1 = 8'h00;
            n_vec++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_err++;
                $display("FAIL nb1_run[%0d]: busy=%b done=%b, required 1 0", k, busy1, done1);
            end
            @(posedge clk); #1;
            e = exp1_q.pop_front();
            n_vec++;
            if (done1 !== 1'b1 || {cout1, sum1} !== e) begin
                n_err++;
                $display("FAIL nb1_result[%0d]: done=%b got %b_%h, required 1 %b_%h",
                         k, done1, cout1, sum1, e[8], e[7:0]);
            end
            @(posedge clk); #1;
            n_vec++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                n_err++;
                $display("FAIL nb1_pulse[%0d]: done=%b busy=%b, required 0 0", k, done1, busy1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        start1 = 1'b0;
        a1 = '0;
        b1 = '0;
        cin1 = 1'b0;
`ifdef KSSEQ_SUB_EN
        sub = 1'b0;
        sub1 = 1'b0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_ripple();
        test_handshake();
        test_back_to_back();
        if (SUB_EN) test_sub();
        test_nbytes1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
